// File: rtl/accum_pkg.sv
// Shared types and arithmetic helpers for the window accumulator.
// The helpers work on a 64-bit word so they can serve any lane width up to 64.
package accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_e;

  localparam int unsigned HELPER_W = 64;
  typedef logic [HELPER_W-1:0] helper_word_t;

  // Sign-extend the low from_w bits of value to the full helper width.
  function automatic helper_word_t sign_extend(input helper_word_t value,
                                               input int unsigned  from_w);
    helper_word_t shifted;
    shifted = value << (HELPER_W - from_w);
    return helper_word_t'($signed(shifted) >>> (HELPER_W - from_w));
  endfunction

  // Most positive (negative = 0) or most negative (negative = 1) to_w-bit value.
  function automatic helper_word_t saturate_limit(input logic        negative,
                                                  input int unsigned to_w);
    helper_word_t max_val;
    max_val = (helper_word_t'(1) << (to_w - 1)) - helper_word_t'(1);
    return negative ? ~max_val : max_val;
  endfunction

endpackage

// File: rtl/window_counter.sv
// Window framing: latches and clamps the window length on the first sample of
// each window, counts accepted samples and flags the first and last of them.
module window_counter
  import accum_pkg::*;
#(
  parameter int unsigned MAX_WINDOW = 256,
  parameter int unsigned LEN_W      = $clog2(MAX_WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic             clear_i,
  input  logic [LEN_W-1:0] cfg_window_i,
  output logic             first_o,
  output logic             last_o
);

  win_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] cfg_len;

  // Effective length of a window that would start now: 0 means 1, clamp to MAX_WINDOW.
  always_comb begin
    if (cfg_window_i == '0) begin
      cfg_len = LEN_W'(1);
    end else if (cfg_window_i > LEN_W'(MAX_WINDOW)) begin
      cfg_len = LEN_W'(MAX_WINDOW);
    end else begin
      cfg_len = cfg_window_i;
    end
  end

  // A window opened in IDLE closes at once when its fresh length is 1.
  assign first_o = accept_i && (state_q == IDLE);
  assign last_o  = accept_i && ((state_q == IDLE) ? (cfg_len == LEN_W'(1))
                                                  : (count_q == len_q - LEN_W'(1)));

  // Next-state logic for the framing FSM, count and length latch.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    if (clear_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (accept_i) begin
      unique case (state_q)
        IDLE: begin
          len_d = cfg_len;
          if (!last_o) begin
            state_d = ACCUM;
            count_d = LEN_W'(1);
          end
        end
        ACCUM: begin
          if (last_o) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Framing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= LEN_W'(1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/window_accumulator.sv
// Multi-lane windowed accumulator with a one-deep result register.
// Each lane sums a window of signed samples; the result is offered on a
// valid/ready port one cycle after the last sample of the window.
// Define WINDOW_ACCUMULATOR_SAT_EN to saturate each addition instead of wrapping.
// Lane widths must satisfy DATA_W <= ACC_W <= 64.
module window_accumulator
  import accum_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 40,
  parameter int MAX_WINDOW = 256
) (
  input  logic                               clk,
  input  logic                               accumulator_reset_n,
  input  logic [$clog2(MAX_WINDOW+1)-1:0]    cfg_window,
  input  logic                               in_clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS*DATA_W-1:0]         in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS*ACC_W-1:0]          out_sum,
  output logic [CHANNELS-1:0]                out_ovf
);

  typedef logic [ACC_W-1:0] acc_t;

  logic accept, first, last;

  acc_t                  acc_q [CHANNELS];
  acc_t                  acc_d [CHANNELS];
  logic [CHANNELS-1:0]   ovf_q, ovf_d;
  logic [CHANNELS*ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CHANNELS-1:0]   out_ovf_q, out_ovf_d;
  logic                  out_valid_q, out_valid_d;

  acc_t                  sample_ext [CHANNELS];
  acc_t                  final_sum  [CHANNELS];
  logic [ACC_W:0]        wide_sum   [CHANNELS];
  logic [CHANNELS-1:0]   add_ovf, final_ovf;

  assign in_ready = !in_clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  window_counter #(
    .MAX_WINDOW (MAX_WINDOW)
  ) u_window_counter (
    .clk          (clk),
    .rst_n        (accumulator_reset_n),
    .accept_i     (accept),
    .clear_i      (in_clear),
    .cfg_window_i (cfg_window),
    .first_o      (first),
    .last_o       (last)
  );

  // Per-lane sum including the current sample; the first sample bypasses the adder.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sample_ext[k] = acc_t'(sign_extend(helper_word_t'(in_data[k*DATA_W +: DATA_W]), DATA_W));
      wide_sum[k]   = {acc_q[k][ACC_W-1], acc_q[k]} + {sample_ext[k][ACC_W-1], sample_ext[k]};
      add_ovf[k]    = wide_sum[k][ACC_W] ^ wide_sum[k][ACC_W-1];
      if (first) begin
        final_sum[k] = sample_ext[k];
        final_ovf[k] = 1'b0;
      end else begin
`ifdef WINDOW_ACCUMULATOR_SAT_EN
        final_sum[k] = add_ovf[k] ? acc_t'(saturate_limit(wide_sum[k][ACC_W], ACC_W))
                                  : wide_sum[k][ACC_W-1:0];
`else
        final_sum[k] = wide_sum[k][ACC_W-1:0];
`endif
        final_ovf[k] = ovf_q[k] | add_ovf[k];
      end
    end
  end

  // Accumulator and result-register next state.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      acc_d[k] = acc_q[k];
    end
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_ready;

    if (in_clear) begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_d[k] = '0;
      end
      ovf_d = '0;
    end else if (accept) begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_d[k] = final_sum[k];
      end
      ovf_d = final_ovf;
    end

    if (last) begin
      out_valid_d = 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        out_sum_d[k*ACC_W +: ACC_W] = final_sum[k];
      end
      out_ovf_d = final_ovf;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge accumulator_reset_n) begin
    if (!accumulator_reset_n) begin
      // NOTE: the per-lane accumulator array is reset explicitly; it is a handful of flops, not a RAM, and must read 0 after reset.
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= '0;
      end
      ovf_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= acc_d[k];
      end
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: two instances (10-bit and 8-bit accumulators)
// share one stimulus stream and are compared against a window-level model.
module tb_window_accumulator;

  localparam int CH   = 4;
  localparam int DW   = 8;
  localparam int AW   = 10;
  localparam int NW   = 8;
  localparam int MAXW = 16;
  localparam int LW   = $clog2(MAXW + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LW-1:0]     cfg_window;
  logic              in_clear, in_valid, out_ready;
  logic [CH*DW-1:0]  in_data;
  logic              rdy_w, rdy_n, vld_w, vld_n;
  logic [CH*AW-1:0]  sum_w;
  logic [CH*NW-1:0]  sum_n;
  logic [CH-1:0]     ovf_w, ovf_n;

  always #5 clk = ~clk;

  window_accumulator #(.CHANNELS(CH), .DATA_W(DW), .ACC_W(AW), .MAX_WINDOW(MAXW)) dut_w (
    .clk(clk), .accumulator_reset_n(rst_n), .cfg_window(cfg_window), .in_clear(in_clear),
    .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data), .out_valid(vld_w),
    .out_ready(out_ready), .out_sum(sum_w), .out_ovf(ovf_w));

  window_accumulator #(.CHANNELS(CH), .DATA_W(DW), .ACC_W(NW), .MAX_WINDOW(MAXW)) dut_n (
    .clk(clk), .accumulator_reset_n(rst_n), .cfg_window(cfg_window), .in_clear(in_clear),
    .in_valid(in_valid), .in_ready(rdy_n), .in_data(in_data), .out_valid(vld_n),
    .out_ready(out_ready), .out_sum(sum_n), .out_ovf(ovf_n));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int lane_w(int k);
    return int'($signed(sum_w[k*AW +: AW]));
  endfunction

  function automatic int lane_n(int k);
    return int'($signed(sum_n[k*NW +: NW]));
  endfunction

  // ---------------- reference model: whole windows of samples ----------------
  typedef int lanes_t[CH];
  lanes_t           win_q[$];
  int               m_len;
  bit               m_vld;
  int               m_sum_w[CH], m_sum_n[CH];
  logic [CH-1:0]    m_ovf_w, m_ovf_n;

  function automatic void model_reset();
    win_q.delete();
    m_len = 1;
    m_vld = 0;
    m_ovf_w = '0;
    m_ovf_n = '0;
    for (int k = 0; k < CH; k++) begin
      m_sum_w[k] = 0;
      m_sum_n[k] = 0;
    end
  endfunction

  // Sum lane k of the collected window in a w-bit signed accumulator.
  function automatic void fold_lane(input int k, input int w, output int sum, output bit ovf);
    longint lo, hi, a, t;
    lo  = -(longint'(1) << (w - 1));
    hi  = (longint'(1) << (w - 1)) - 1;
    a   = win_q[0][k];
    ovf = 0;
    for (int i = 1; i < win_q.size(); i++) begin
      t = a + win_q[i][k];
      if (t > hi || t < lo) begin
        ovf = 1;
`ifdef WINDOW_ACCUMULATOR_SAT_EN
        t = (t > hi) ? hi : lo;
`else
        t = (t > hi) ? t - (longint'(1) << w) : t + (longint'(1) << w);
`endif
      end
      a = t;
    end
    sum = int'(a);
  endfunction

  function automatic bit model_ready(input bit c, input bit r);
    return !c && (!m_vld || r);
  endfunction

  function automatic void model_step(input bit v, input bit c, input bit r, input int cfg,
                                     input lanes_t d);
    bit acc, o;
    acc = v && model_ready(c, r);
    if (m_vld && r) m_vld = 0;
    if (c) begin
      win_q.delete();
    end else if (acc) begin
      if (win_q.size() == 0) m_len = (cfg == 0) ? 1 : (cfg > MAXW) ? MAXW : cfg;
      win_q.push_back(d);
      if (win_q.size() == m_len) begin
        for (int k = 0; k < CH; k++) begin
          fold_lane(k, AW, m_sum_w[k], o); m_ovf_w[k] = o;
          fold_lane(k, NW, m_sum_n[k], o); m_ovf_n[k] = o;
        end
        m_vld = 1;
        win_q.delete();
      end
    end
  endfunction

  task automatic check_outputs();
    check("out_valid_w", vld_w, m_vld);
    check("out_valid_n", vld_n, m_vld);
    check("out_ovf_w", ovf_w, m_ovf_w);
    check("out_ovf_n", ovf_n, m_ovf_n);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("out_sum_w[%0d]", k), lane_w(k), m_sum_w[k]);
      check($sformatf("out_sum_n[%0d]", k), lane_n(k), m_sum_n[k]);
    end
  endtask

  // One clock cycle: apply inputs, check in_ready, advance model, check outputs.
  task automatic drive(input bit v, input bit c, input bit r, input int cfg, input lanes_t d,
                       output bit rdy_seen);
    in_valid   = v;
    in_clear   = c;
    out_ready  = r;
    cfg_window = LW'(cfg);
    for (int k = 0; k < CH; k++) in_data[k*DW +: DW] = DW'(d[k]);
    #1;
    check("in_ready_w", rdy_w, model_ready(c, r));
    check("in_ready_n", rdy_n, model_ready(c, r));
    rdy_seen = rdy_w;
    model_step(v, c, r, cfg, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    in_valid  = 1'b0;
    in_clear  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst.out_valid_w", vld_w, 0);
    check("rst.out_valid_n", vld_n, 0);
    check("rst.out_sum_w", sum_w, 0);
    check("rst.out_sum_n", sum_n, 0);
    check("rst.out_ovf_w", ovf_w, 0);
    check("rst.in_ready", rdy_w, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            v, c, r;
    int            cfg;
    lanes_t        d;
    bit            e_rdy, e_vld;
    lanes_t        e_sum;
    logic [CH-1:0] e_ovf;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input bit v, input bit c, input bit r, input int cfg,
                                  input lanes_t d, input bit e_rdy, input bit e_vld,
                                  input lanes_t e_sum, input logic [CH-1:0] e_ovf);
    vec_t t;
    t.v = v; t.c = c; t.r = r; t.cfg = cfg; t.d = d;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_sum = e_sum; t.e_ovf = e_ovf;
    vecs.push_back(t);
  endfunction

`ifdef WINDOW_ACCUMULATOR_SAT_EN
  localparam int W_OV0 = 511;  localparam int W_OV1 = -512;
  localparam int N_OV0 = 127;  localparam int N_OV1 = -128;
`else
  localparam int W_OV0 = -389; localparam int W_OV1 = 384;
  localparam int N_OV0 = -56;  localparam int N_OV1 = 56;
`endif

  initial begin
    lanes_t z, q, f, s, sums;
    bit     rdy;
    logic [7:0] b;

    z = '{0, 0, 0, 0};
    q = '{4, 8, 12, 16};
    f = '{5, 5, 5, 5};
    s = '{127, -128, 100, -100};
    sums = '{W_OV0, W_OV1, 500, -500};

    for (int i = 0; i < 3; i++) add_vec(1, 0, 1, 4, '{1, 2, 3, 4}, 1, 0, z, '0);
    add_vec(1, 0, 1, 4, '{1, 2, 3, 4}, 1, 1, q, '0);
    add_vec(0, 0, 1, 4, z, 1, 0, q, '0);
    add_vec(1, 0, 1, 4, '{9, 9, 9, 9}, 1, 0, q, '0);
    add_vec(1, 0, 1, 4, '{9, 9, 9, 9}, 1, 0, q, '0);
    add_vec(1, 1, 1, 4, '{50, 50, 50, 50}, 0, 0, q, '0);
    for (int i = 0; i < 3; i++) add_vec(1, 0, 1, 4, f, 1, 0, q, '0);
    add_vec(1, 0, 1, 4, f, 1, 1, '{20, 20, 20, 20}, '0);
    add_vec(1, 0, 1, 0, '{-3, 7, 0, 1}, 1, 1, '{-3, 7, 0, 1}, '0);
    add_vec(1, 0, 1, 0, '{2, 2, 2, 2}, 1, 1, '{2, 2, 2, 2}, '0);
    add_vec(0, 0, 1, 0, z, 1, 0, '{2, 2, 2, 2}, '0);
    for (int i = 0; i < 4; i++) add_vec(1, 0, 1, 5, s, 1, 0, '{2, 2, 2, 2}, '0);
    add_vec(1, 0, 1, 5, s, 1, 1, sums, 4'b0011);
    add_vec(0, 0, 0, 5, z, 0, 1, sums, 4'b0011);
    add_vec(0, 0, 1, 5, z, 1, 0, sums, 4'b0011);

    cfg_window = '0;
    in_data    = '0;
    pulse_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].r, vecs[i].cfg, vecs[i].d, rdy);
      check($sformatf("vec%0d.in_ready", i), rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d.out_valid", i), vld_w, vecs[i].e_vld);
      check($sformatf("vec%0d.out_ovf", i), ovf_w, vecs[i].e_ovf);
      for (int k = 0; k < CH; k++)
        check($sformatf("vec%0d.out_sum[%0d]", i, k), lane_w(k), vecs[i].e_sum[k]);
    end

    // Continuous stream, window 3: a result after every third sample.
    for (int i = 1; i <= 12; i++) begin
      drive(1, 0, 1, 3, '{i, i, i, i}, rdy);
      check($sformatf("stream%0d.out_valid", i), vld_w, (i % 3) == 0);
      if ((i % 3) == 0) check($sformatf("stream%0d.sum", i), lane_w(2), 9 * (i / 3 - 1) + 6);
    end

    // Back-pressure: result held, input stalled.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 2, '{7, 7, 7, 7}, rdy);
      check($sformatf("hold%0d.in_ready", i), rdy, 0);
      check($sformatf("hold%0d.out_sum", i), lane_w(0), 33);
    end
    drive(1, 0, 1, 2, '{7, 7, 7, 7}, rdy);
    check("release.in_ready", rdy, 1);
    check("release.out_valid", vld_w, 0);
    drive(1, 0, 1, 2, '{7, 7, 7, 7}, rdy);
    check("fresh.out_sum", lane_w(3), 14);

    // Two samples of 100 overflow an 8-bit accumulator.
    drive(1, 0, 1, 2, '{100, -100, 100, 0}, rdy);
    drive(1, 0, 1, 2, '{100, -100, 100, 0}, rdy);
    check("ovf8.sum0", lane_n(0), N_OV0);
    check("ovf8.sum1", lane_n(1), N_OV1);
    check("ovf8.flags", ovf_n, 4'b0111);
    check("ovf10.sum0", lane_w(0), 200);
    check("ovf10.flags", ovf_w, 0);

    // Oversized window length clamps to MAX_WINDOW.
    for (int i = 1; i <= MAXW; i++) begin
      drive(1, 0, 1, 31, '{1, 1, 1, 1}, rdy);
      if (i == MAXW - 1) check("clamp.early", vld_w, 0);
    end
    check("clamp.valid", vld_w, 1);
    check("clamp.sum", lane_w(1), MAXW);

    // Reset mid-window, then with a result pending.
    drive(1, 0, 1, 4, '{3, 3, 3, 3}, rdy);
    drive(1, 0, 1, 4, '{3, 3, 3, 3}, rdy);
    pulse_reset();
    drive(1, 0, 1, 1, '{9, 9, 9, 9}, rdy);
    drive(0, 0, 0, 1, z, rdy);
    check("pending.out_valid", vld_w, 1);
    pulse_reset();
    drive(1, 0, 1, 2, '{3, 3, 3, 3}, rdy);
    check("post_rst.in_ready", rdy, 1);
    drive(1, 0, 1, 2, '{4, 4, 4, 4}, rdy);
    check("post_rst.sum", lane_w(0), 7);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      lanes_t d;
      int     cfg;
      for (int k = 0; k < CH; k++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h7f : 8'h80;
        d[k] = int'($signed(b));
      end
      cfg = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, cfg, d, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
